// File: rtl/stat_pkg.sv
// Shared types and constants for the stat bank: wellness states, default
// geometry and the named stat slots used by the display/input logic.
package stat_pkg;

  localparam int STAT_W_DEF    = 4;
  localparam int NUM_STATS_DEF = 6;

  localparam int HUNGER    = 0;
  localparam int HAPPINESS = 1;
  localparam int HEALTH    = 2;
  localparam int HYGIENE   = 3;
  localparam int ENERGY    = 4;
  localparam int SOCIAL    = 5;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_WARN     = 2'd1,
    ST_CRITICAL = 2'd2,
    ST_DEAD     = 2'd3
  } status_e;

endpackage

// File: rtl/stat_bank_if.sv
// Stat bank bus: decrement requests and tick selector in, stat vector,
// tick pulse, high flags and wellness status out.
interface stat_bank_if
  import stat_pkg::*;
#(
  parameter int NUM_STATS = NUM_STATS_DEF,
  parameter int STAT_W    = STAT_W_DEF,
  parameter int SEL_W     = $clog2(NUM_STATS)
);
  logic [NUM_STATS-1:0]        inputs;
  logic [SEL_W-1:0]            random;
  logic [NUM_STATS*STAT_W-1:0] stats;
  logic                        tick;
  logic [NUM_STATS-1:0]        high;
  status_e                     status;

  modport master (
    output inputs, random,
    input  stats, tick, high, status
  );

  modport slave (
    input  inputs, random,
    output stats, tick, high, status
  );
endinterface

// File: rtl/stat_bank_sat_counter.sv
// One saturating up/down stat counter; simultaneous inc and dec cancel.
module sat_counter #(
  parameter int             W    = 4,
  parameter logic [W-1:0]   INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic [W-1:0] inc_step_i,
  input  logic [W-1:0] dec_step_i,
  output logic [W-1:0] value_o
);
  localparam logic [W:0] MAX_EXT = {1'b0, {W{1'b1}}};

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum, diff;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sum   = {1'b0, cnt_q} + {1'b0, inc_step_i};
    diff  = {1'b0, cnt_q} - {1'b0, dec_step_i};
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      cnt_d = (sum > MAX_EXT) ? MAX_EXT[W-1:0] : sum[W-1:0];
    end else if (dec_i && !inc_i) begin
      cnt_d = diff[W] ? '0 : diff[W-1:0];  // borrow out means underflow
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= INIT;
    else     cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;
endmodule

// File: rtl/stat_bank.sv
// Stat bank: NUM_STATS saturating counters, tick timer and wellness FSM.
// Define STAT_BANK_ROUND_ROBIN_EN to pick the tick target round-robin instead of from random.
module stat_bank
  import stat_pkg::*;
#(
  parameter int NUM_STATS   = NUM_STATS_DEF,
  parameter int STAT_W      = STAT_W_DEF,
  parameter int TICK_CYCLES = 10000000,
  parameter int INC_STEP    = 1,
  parameter int DEC_STEP    = 1,
  parameter int INIT_VAL    = 8,
  parameter int WARN_LEVEL  = 12,
  parameter int CRIT_TICKS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  stat_bank_if.slave  bus
);
  localparam int SEL_W  = $clog2(NUM_STATS);
  localparam int TMR_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CRIT_W = $clog2(CRIT_TICKS + 1);

  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] WARN_V   = STAT_W'(WARN_LEVEL);
  localparam logic [STAT_W-1:0] INC_V    = STAT_W'(INC_STEP);
  localparam logic [STAT_W-1:0] DEC_V    = STAT_W'(DEC_STEP);
  localparam logic [STAT_W-1:0] INIT_V   = STAT_W'(INIT_VAL);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TICK_CYCLES - 1);

  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 tick;
  logic [SEL_W-1:0]     sel;
  logic [STAT_W-1:0]    stat_val [NUM_STATS];
  logic [NUM_STATS-1:0] at_max;
  logic [NUM_STATS-1:0] high;

  assign tick    = (timer_q == TMR_LAST);
  assign timer_d = tick ? '0 : timer_q + TMR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end

`ifdef STAT_BANK_ROUND_ROBIN_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (tick) ptr_d = (ptr_q == SEL_W'(NUM_STATS - 1)) ? '0 : ptr_q + SEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign sel = ptr_q;
`else
  assign sel = bus.random;
`endif

  for (genvar i = 0; i < NUM_STATS; i++) begin : g_stat
    sat_counter #(.W(STAT_W), .INIT(INIT_V)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (tick && (sel == SEL_W'(i))),
      .dec_i      (bus.inputs[i]),
      .inc_step_i (INC_V),
      .dec_step_i (DEC_V),
      .value_o    (stat_val[i])
    );
    assign high[i]   = (stat_val[i] >= WARN_V);
    assign at_max[i] = (stat_val[i] == STAT_MAX);
    assign bus.stats[i*STAT_W +: STAT_W] = stat_val[i];
  end

  status_e          state_q, state_d;
  logic [CRIT_W-1:0] crit_q, crit_d;

  always_comb begin
    state_d = state_q;
    crit_d  = crit_q;
    unique case (state_q)
      ST_NORMAL: begin
        if (|at_max)    state_d = ST_CRITICAL;
        else if (|high) state_d = ST_WARN;
      end
      ST_WARN: begin
        if (|at_max)     state_d = ST_CRITICAL;
        else if (!(|high)) state_d = ST_NORMAL;
      end
      ST_CRITICAL: begin
        if (!(|at_max)) begin
          state_d = ST_WARN;
          crit_d  = '0;
        end else if (tick) begin
          crit_d = crit_q + CRIT_W'(1);
          if (crit_d == CRIT_W'(CRIT_TICKS)) state_d = ST_DEAD;
        end
      end
      default: state_d = ST_DEAD;  // sticky until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NORMAL;
      crit_q  <= '0;
    end else begin
      state_q <= state_d;
      crit_q  <= crit_d;
    end
  end

  assign bus.tick   = tick;
  assign bus.high   = high;
  assign bus.status = state_q;
endmodule
